// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED PWM controller:
// channel mode encodings and a width helper for index/counter buses.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  // ceil(log2(n)) but never below 1, so a single-entry index still has a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: latched mode/period/duty, tick-driven counter and
// registered led / pulse_done outputs.
module led_chan
  import led_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [1:0] RST_MODE = MODE_OFF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick,
  input  logic             wr,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             led,
  output logic             pulse_done
);

  logic [1:0]       mode_q,   mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q,   duty_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             led_q,    led_d;
  logic             done_q,   done_d;
  logic [CNT_W-1:0] last_s;

  // next-state: a write wins over a same-cycle tick and restarts the counter
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    last_s   = (period_q == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (period_q - CNT_W'(1));

    if (wr) begin
      period_d = cfg_period;
      duty_d   = cfg_duty;
      cnt_d    = {CNT_W{1'b0}};
      if ((cfg_mode == MODE_PULSE) && (cfg_duty == {CNT_W{1'b0}})) begin
        // zero-length pulse finishes at once and never lights the LED
        mode_d = MODE_OFF;
        done_d = 1'b1;
      end else begin
        mode_d = cfg_mode;
      end
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (cnt_q >= last_s) begin
            cnt_d = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MODE_PULSE: begin
          if (cnt_q == (duty_q - CNT_W'(1))) begin
            mode_d = MODE_OFF;
            cnt_d  = {CNT_W{1'b0}};
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end

    case (mode_d)
      MODE_OFF:   led_d = 1'b0;
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = (cnt_d < duty_d);
      MODE_PULSE: led_d = 1'b1;
      default:    led_d = 1'b0;
    endcase
  end

  // channel state registers with synchronous active-low reset
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mode_q   <= RST_MODE;
      period_q <= {CNT_W{1'b0}};
      duty_q   <= {CNT_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  assign led        = led_q;
  assign pulse_done = done_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: shared prescaler tick, config-write decode
// and one led_chan per output.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int         N_LED    = 4,
  parameter int         CNT_W    = 16,
  parameter int         PRESCALE = 50000,
  parameter logic [1:0] RST_MODE = 2'd0
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           cfg_we,
  input  logic [clog2_min1(N_LED)-1:0]   cfg_ch,
  input  logic [1:0]                     cfg_mode,
  input  logic [CNT_W-1:0]               cfg_period,
  input  logic [CNT_W-1:0]               cfg_duty,
  output logic [N_LED-1:0]               led,
  output logic [N_LED-1:0]               pulse_done,
  output logic                           tick
);

  localparam int CH_W = clog2_min1(N_LED);
  localparam int PS_W = clog2_min1(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps_cnt_q, ps_cnt_d;
  logic             tick_q,   tick_d;
  logic [N_LED-1:0] wr_s;

  // prescaler wrap; tick is registered so it is 0 in reset and solid 1 for PRESCALE=1
  always_comb begin
    if (ps_cnt_q == PS_LAST) begin
      ps_cnt_d = {PS_W{1'b0}};
    end else begin
      ps_cnt_d = ps_cnt_q + PS_W'(1);
    end
    tick_d = (ps_cnt_q == PS_LAST);
  end

  // prescaler registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ps_cnt_q <= {PS_W{1'b0}};
      tick_q   <= 1'b0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign tick = tick_q;

  // address decode; indices >= N_LED match no channel and are dropped
  always_comb begin
    wr_s = {N_LED{1'b0}};
    for (int i = 0; i < N_LED; i++) begin
      wr_s[i] = cfg_we & (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_LED; g++) begin : g_chan
    led_chan #(
      .CNT_W    (CNT_W),
      .RST_MODE (RST_MODE)
    ) u_chan (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .tick       (tick_q),
      .wr         (wr_s[g]),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .led        (led[g]),
      .pulse_done (pulse_done[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: one instance at PRESCALE=4 and one at
// PRESCALE=1, sharing clock, reset and config buses.
module tb_led_pwm_ctrl;

  logic        clk;
  logic        rst_n;
  logic        we4, we1;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_period, cfg_duty;
  logic [4:0]  led4, pd4, led1, pd1;
  logic        tick4, tick1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  ch;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [15:0] duty;
    logic [4:0]  exp_led;
  } vec_t;

  vec_t vecs[11];

  led_pwm_ctrl #(.N_LED(5), .CNT_W(16), .PRESCALE(4), .RST_MODE(2'd0)) u_dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .cfg_we(we4), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .led(led4), .pulse_done(pd4), .tick(tick4)
  );

  led_pwm_ctrl #(.N_LED(5), .CNT_W(16), .PRESCALE(1), .RST_MODE(2'd0)) u_dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .cfg_we(we1), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .led(led1), .pulse_done(pd1), .tick(tick1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // one-cycle config write on the selected instance; returns at the negedge after the write edge
  task automatic wr(input bit sel1, input logic [2:0] ch, input logic [1:0] mode,
                    input logic [15:0] per, input logic [15:0] duty);
    cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_duty = duty;
    if (sel1) we1 = 1'b1; else we4 = 1'b1;
    step();
    we1 = 1'b0; we4 = 1'b0;
  endtask

  initial begin
    logic prev;
    bit   found;

    vecs[0]  = '{3'd3, 2'd1, 16'd0, 16'd0, 5'b01000};
    vecs[1]  = '{3'd3, 2'd0, 16'd0, 16'd0, 5'b00000};
    vecs[2]  = '{3'd0, 2'd1, 16'd0, 16'd0, 5'b00001};
    vecs[3]  = '{3'd4, 2'd1, 16'd0, 16'd0, 5'b10001};
    vecs[4]  = '{3'd2, 2'd2, 16'd5, 16'd0, 5'b10001};
    vecs[5]  = '{3'd2, 2'd2, 16'd5, 16'd7, 5'b10101};
    vecs[6]  = '{3'd5, 2'd1, 16'd0, 16'd0, 5'b10101};
    vecs[7]  = '{3'd7, 2'd1, 16'd0, 16'd0, 5'b10101};
    vecs[8]  = '{3'd2, 2'd0, 16'd0, 16'd0, 5'b10001};
    vecs[9]  = '{3'd0, 2'd0, 16'd0, 16'd0, 5'b10000};
    vecs[10] = '{3'd4, 2'd0, 16'd0, 16'd0, 5'b00000};

    rst_n = 1'b0; we4 = 1'b0; we1 = 1'b0;
    cfg_ch = 3'd0; cfg_mode = 2'd0; cfg_period = 16'd0; cfg_duty = 16'd0;

    // reset held 5 cycles
    @(negedge clk);
    for (int i = 0; i < 5; i++) step();
    chk("rst_led4", {27'd0, led4}, 32'd0);
    chk("rst_pd4", {27'd0, pd4}, 32'd0);
    chk("rst_tick4", {31'd0, tick4}, 32'd0);
    chk("rst_led1", {27'd0, led1}, 32'd0);
    chk("rst_pd1", {27'd0, pd1}, 32'd0);
    chk("rst_tick1", {31'd0, tick1}, 32'd0);

    // tick cadence after release
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("tick4_cadence", {31'd0, tick4}, ((k % 4) == 0) ? 32'd1 : 32'd0);
      chk("tick1_const", {31'd0, tick1}, 32'd1);
    end

    // table: write latency of exactly one edge, bad addresses ignored
    for (int v = 0; v < 11; v++) begin
      chk("tbl_pre_edge", {27'd0, led4}, (v == 0) ? 32'd0 : {27'd0, vecs[v-1].exp_led});
      wr(1'b0, vecs[v].ch, vecs[v].mode, vecs[v].period, vecs[v].duty);
      chk("tbl_led", {27'd0, led4}, {27'd0, vecs[v].exp_led});
      chk("tbl_pd", {27'd0, pd4}, 32'd0);
    end

    // BLINK duty=0 constantly low, duty=7 constantly high
    wr(1'b0, 3'd2, 2'd2, 16'd5, 16'd0);
    for (int i = 0; i < 25; i++) begin
      chk("blink_d0", {31'd0, led4[2]}, 32'd0);
      step();
    end
    wr(1'b0, 3'd2, 2'd2, 16'd5, 16'd7);
    for (int i = 0; i < 25; i++) begin
      chk("blink_d7", {31'd0, led4[2]}, 32'd1);
      step();
    end
    wr(1'b0, 3'd2, 2'd0, 16'd0, 16'd0);

    // BLINK period=5 duty=2 at 4 clocks/tick: 8 high, 12 low
    wr(1'b0, 3'd1, 2'd2, 16'd5, 16'd2);
    prev = led4[1];
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (!prev && led4[1]) found = 1'b1;
      prev = led4[1];
    end
    chk("blink_rise_seen", {31'd0, found}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      chk("blink_p5d2", {31'd0, led4[1]}, ((i % 20) < 8) ? 32'd1 : 32'd0);
      chk("blink_others", {27'd0, led4 & 5'b11101}, 32'd0);
      step();
    end
    wr(1'b0, 3'd1, 2'd0, 16'd0, 16'd0);

    // write landing on a tick cycle: counter restarts at 0, not 1
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (tick4) found = 1'b1;
      else step();
    end
    chk("collide_tick_seen", {31'd0, found}, 32'd1);
    wr(1'b0, 3'd1, 2'd2, 16'd2, 16'd1);
    for (int i = 0; i < 12; i++) begin
      chk("collide_blink", {31'd0, led4[1]}, (((i / 4) % 2) == 0) ? 32'd1 : 32'd0);
      step();
    end
    wr(1'b0, 3'd1, 2'd0, 16'd0, 16'd0);

    // PULSE duty=3 at tick every cycle
    chk("pulse_pre", {31'd0, led1[0]}, 32'd0);
    wr(1'b1, 3'd0, 2'd3, 16'd0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      chk("pulse_led_hi", {31'd0, led1[0]}, 32'd1);
      chk("pulse_pd_lo", {27'd0, pd1}, 32'd0);
      step();
    end
    chk("pulse_led_fall", {31'd0, led1[0]}, 32'd0);
    chk("pulse_done", {27'd0, pd1}, 32'd1);
    step();
    chk("pulse_done_once", {27'd0, pd1}, 32'd0);
    chk("pulse_led_off", {31'd0, led1[0]}, 32'd0);

    // PULSE duty=0
    wr(1'b1, 3'd0, 2'd3, 16'd0, 16'd0);
    chk("pulse0_done", {27'd0, pd1}, 32'd1);
    chk("pulse0_led", {31'd0, led1[0]}, 32'd0);
    step();
    chk("pulse0_done_once", {27'd0, pd1}, 32'd0);
    chk("pulse0_led_stay", {31'd0, led1[0]}, 32'd0);

    // rewrite a running pulse to ON: no pulse_done, led stays lit
    wr(1'b1, 3'd2, 2'd3, 16'd0, 16'd10);
    for (int i = 0; i < 3; i++) step();
    wr(1'b1, 3'd2, 2'd1, 16'd0, 16'd0);
    for (int i = 0; i < 15; i++) begin
      chk("rewrite_led", {31'd0, led1[2]}, 32'd1);
      chk("rewrite_no_done", {27'd0, pd1}, 32'd0);
      step();
    end

    // reset in the middle of a fresh pulse
    wr(1'b1, 3'd2, 2'd3, 16'd0, 16'd10);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    #2;
    chk("sync_rst_hold", {31'd0, led1[2]}, 32'd1);
    step();
    chk("midrst_led", {27'd0, led1}, 32'd0);
    chk("midrst_pd", {27'd0, pd1}, 32'd0);
    chk("midrst_tick", {31'd0, tick1}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("postrst_no_done", {27'd0, pd1}, 32'd0);
      chk("postrst_led", {27'd0, led1}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Multi-channel LED driver; parametrised successor to the single fixed-rate blinker.
- Each channel is independently configured by a simple write port with one of four modes: OFF, ON, BLINK (programmable period/duty) or PULSE (one-shot).
- A shared prescaler derives a time-base tick from sys_clk.
- Sits between board top-level LED pins and a control source (CPU register bank or test FSM).

Parameters:
- N_LED, 4, number of LED channels (1..16)
- CNT_W, 16, width of per-channel period/duty counters in ticks
- PRESCALE, 50000, sys_clk cycles per tick (>=1); 50000 gives 1 ms at 50 MHz
- RST_MODE, 2'd0, mode every channel takes at reset (default OFF)

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  $clog2(N_LED) (min 1)  channel index for the write
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PULSE
- cfg_period  in  CNT_W  BLINK period in ticks
- cfg_duty  in  CNT_W  BLINK on-time / PULSE length in ticks
- led  out  N_LED  registered LED outputs, 1 = lit
- pulse_done  out  N_LED  one-cycle strobe when a channel's PULSE completes
- tick  out  1  prescaler tick, for debug/cascading

Behaviour:
- Reset: sys_rst_n sampled only on the sys_clk rising edge. While low:
  - prescaler = 0, tick = 0
  - all channel counters = 0, modes = RST_MODE, period = duty = 0
  - led = 0, pulse_done = 0
  - Reset mid-PULSE aborts the pulse without a pulse_done strobe.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick = 1 for exactly one cycle when the count equals PRESCALE-1. With PRESCALE=1, tick is permanently 1 after reset.
- Config write: at the edge where cfg_we=1:
  - the addressed channel latches mode, period and duty, and clears its counter to 0;
  - led[ch] shows the new mode's value at the next edge (1-cycle latency).
  - cfg_ch >= N_LED: write ignored.
  - Other channels are unaffected.
- OFF: led=0; counter held at 0.
- ON: led=1; counter held at 0.
- BLINK:
  - Counter increments on tick and wraps to 0 after reaching eff_period-1, where eff_period = max(period,1).
  - led = (counter < duty), registered.
  - duty=0 gives constantly off; duty>=period gives constantly on.
  - Counter arithmetic is unsigned CNT_W; no overflow is possible because the wrap occurs before 2^CNT_W-1.
- PULSE:
  - led=1 from the cycle after the write.
  - Counter increments on tick; when counter == duty-1 on a tick, the next edge forces mode to OFF, led=0, pulse_done[ch]=1 for one cycle.
  - duty=0: immediately OFF with pulse_done asserted at the next edge; led never rises.
  - A rewrite during PULSE restarts from the new config; no pulse_done for the aborted pulse.
- Simultaneous events: a cfg write to a channel on a tick cycle takes priority over that tick; the counter becomes 0, not 1. Ticks on other channels proceed normally.
- All outputs come from registers; no combinational path from inputs to led/pulse_done.

Decomposition:
- Package led_pkg:
  - mode localparams MODE_OFF/ON/BLINK/PULSE (2-bit)
  - function clog2_min1 for the cfg_ch width
- Sub-module led_chan:
  - one channel's mode/period/duty registers, counter, led and pulse_done flops
  - inputs: sys_clk, sys_rst_n, tick, wr (= cfg_we & cfg_ch==i), cfg fields
  - instantiated N_LED times by generate
- Top: prescaler, address decode, generate loop.

Test Plan:
- Reset and defaults:
  - Stimulus: PRESCALE=4, hold sys_rst_n=0 for 5 cycles, then release.
  - Required: led=0, pulse_done=0; tick first high at cycle 4 after release, then every 4 cycles.
  - Also: asserting sys_rst_n=0 without a clock edge leaves outputs unchanged (checks synchronous reset).
- BLINK:
  - Stimulus: PRESCALE=4, ch1 BLINK with period=5, duty=2.
  - Required: led[1] high for 8 cycles, then low for 12, repeating; other channels stay 0.
  - Also: duty=0 gives constantly low; duty=7 gives constantly high.
- PULSE:
  - Stimulus: PRESCALE=1, ch0 PULSE with duty=3.
  - Required: led[0]=1 for 3 cycles after the write cycle, then 0; pulse_done[0]=1 for exactly one cycle, coincident with led falling.
  - Then: duty=0 gives pulse_done next cycle and led stays 0.
- Rewrite/abort:
  - Stimulus: start PULSE duty=10 on ch2, rewrite ch2 to ON at tick 4; then reset mid-pulse on a fresh PULSE.
  - Required: led[2] stays 1 and no pulse_done on the rewrite; the mid-pulse reset clears led with no pulse_done.
- Write/tick collision and bad address:
  - Stimulus: issue cfg_we on a tick cycle; then issue a write with cfg_ch=N_LED.
  - Required: the written channel's counter reads 0 after the colliding write; the out-of-range write changes no led state.
- ON/OFF latency:
  - Stimulus: write ON to ch3, then OFF.
  - Required: led[3] changes exactly one edge after each cfg_we.
